// File: rtl/proc_pkg.sv
// Shared processor definitions.
//   multState_t   : multiplier FSM state encoding
//   DEFAULT_WIDTH : datapath width shared by accumulator, MDR and multiplier
package proc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } multState_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/seq_mult_dp.sv
// Shift-and-add multiplier datapath: multiplicand/multiplier shift registers,
// partial-product accumulator and step counter.
//   clk, rst  : clock, async active-high reset
//   load      : capture operands, clear accumulator and count
//   step      : perform one shift-and-add iteration
//   opA, opB  : multiplicand, multiplier
//   accSum    : accumulator value after the current iteration
//   lastStep  : current iteration is the final one
module seq_mult_dp
    import proc_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     opA,
    input  logic [WIDTH-1:0]     opB,
    output logic [2*WIDTH-1:0]   accSum,
    output logic                 lastStep
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   mplierShift;
    logic [CW-1:0]      count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else if (load) begin
            mcand  <= {{WIDTH{1'b0}}, opA};
            mplier <= opB;
            acc    <= '0;
            count  <= '0;
        end else if (step) begin
            acc    <= accSum;
            mcand  <= mcand << 1;
            mplier <= mplierShift;
            count  <= count + 1'b1;
        end
    end

    // mcand has at most WIDTH significant bits left of its shift origin, so
    // the 2*WIDTH-bit sum can never carry out.
    always_comb begin
        accSum      = mplier[0] ? (acc + mcand) : acc;
        mplierShift = mplier >> 1;
        // With early exit, stop once no multiplier bits remain to add in.
        lastStep    = (count == LAST) || (EARLY_EXIT && (mplierShift == '0));
    end

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle unsigned shift-and-add multiplier (control FSM + result flags).
//   clk, rst  : clock, async active-high reset
//   start     : multiply request (mullACC), level-sensitive, accepted in IDLE
//   op_a, op_b: multiplicand (accumulator), multiplier (MDR)
//   busy      : state is RUN
//   done      : state is DONE (mullDone)
//   product   : registered 2*WIDTH-bit product
//   result    : low WIDTH bits of product, for accumulator load
//   ovf       : upper half of product nonzero
//   zero      : product is zero
module seq_multiplier
    import proc_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     result,
    output logic                 ovf,
    output logic                 zero
);

    multState_t         state, stateNext;
    logic               load, step, lastStep;
    logic [2*WIDTH-1:0] accSum;

    seq_mult_dp #(
        .WIDTH      (WIDTH),
        .EARLY_EXIT (EARLY_EXIT)
    ) uDp (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .opA      (op_a),
        .opB      (op_b),
        .accSum   (accSum),
        .lastStep (lastStep)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    stateNext = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (lastStep) stateNext = DONE;
            end
            // A held start must not retrigger; wait for it to drop.
            DONE: begin
                if (!start) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Product only changes on the final RUN edge, so partial sums never show.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   product <= '0;
        else if (step && lastStep) product <= accSum;
    end

    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    assign result = product[WIDTH-1:0];
    assign ovf    = |product[2*WIDTH-1:WIDTH];
    assign zero   = (product == '0);

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench: one instance without early exit (dut0), one with (dut1),
// both driven by the same stimulus.
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  opA, opB;
    logic        busy0, done0, ovf0, zero0;
    logic        busy1, done1, ovf1, zero1;
    logic [15:0] product0, product1;
    logic [7:0]  result0, result1;

    int vecCnt  = 0;
    int missCnt = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .op_a(opA), .op_b(opB),
        .busy(busy0), .done(done0), .product(product0), .result(result0),
        .ovf(ovf0), .zero(zero0)
    );

    seq_multiplier #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .op_a(opA), .op_b(opB),
        .busy(busy1), .done(done1), .product(product1), .result(result1),
        .ovf(ovf1), .zero(zero1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCnt++;
        if (obs !== exp) begin
            missCnt++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic chkIdleReset(input string tag);
        chk({tag, " busy0"}, busy0, 0);
        chk({tag, " done0"}, done0, 0);
        chk({tag, " prod0"}, product0, 0);
        chk({tag, " ovf0"}, ovf0, 0);
        chk({tag, " zero0"}, zero0, 1);
        chk({tag, " busy1"}, busy1, 0);
        chk({tag, " done1"}, done1, 0);
        chk({tag, " prod1"}, product1, 0);
        chk({tag, " zero1"}, zero1, 1);
    endtask

    // Starts a multiply (start sampled at edge E0) and tracks which edge
    // makes done visible on each instance. holdCycles>0 keeps start high
    // past completion; scramble disturbs operands/start during RUN.
    task automatic runOp(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] expProd, input int expK1,
                         input int holdCycles, input bit scramble);
        int k0 = 0;
        int k1 = 0;
        int busyCnt = 0;
        @(negedge clk);
        opA = a; opB = b; start = 1'b1;
        @(negedge clk);                       // after E0
        if (holdCycles == 0) start = 1'b0;
        if (busy0) busyCnt++;
        for (int k = 1; k <= 20 && (k0 == 0 || k1 == 0); k++) begin
            @(negedge clk);                   // after E(k)
            if (done0 && k0 == 0) k0 = k;
            if (done1 && k1 == 0) k1 = k;
            if (busy0) busyCnt++;
            if (scramble && k <= 3) begin
                opA = 8'($urandom);
                opB = 8'($urandom);
                start = (k == 1);
            end
        end
        chk({tag, " lat0"}, k0, 8);
        chk({tag, " lat1"}, k1, expK1);
        chk({tag, " busyCyc0"}, busyCnt, 8);
        chk({tag, " prod0"}, product0, expProd);
        chk({tag, " prod1"}, product1, expProd);
        chk({tag, " result0"}, result0, expProd[7:0]);
        chk({tag, " ovf0"}, ovf0, (expProd[15:8] != 0));
        chk({tag, " ovf1"}, ovf1, (expProd[15:8] != 0));
        chk({tag, " zero0"}, zero0, (expProd == 0));
        chk({tag, " zero1"}, zero1, (expProd == 0));
        repeat (holdCycles) begin
            @(negedge clk);
            chk({tag, " holdDone"}, {done0, done1, busy0, busy1}, 4'b1100);
        end
        start = 1'b0;
        @(negedge clk);
        chk({tag, " doneFall"}, {done0, done1, busy0, busy1}, 4'b0000);
        chk({tag, " prodHold"}, product0, expProd);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; opA = '0; opB = '0;
        repeat (2) @(negedge clk);
        chkIdleReset("reset");
        rst = 1'b0;
        @(negedge clk);

        runOp("13x11",   8'd13,  8'd11,  16'h008F, 4, 0, 1'b0);
        runOp("255x255", 8'd255, 8'd255, 16'hFE01, 8, 0, 1'b0);
        runOp("200x0",   8'd200, 8'd0,   16'h0000, 1, 0, 1'b0);
        runOp("7x5",     8'd7,   8'd5,   16'd35,   3, 0, 1'b0);
        runOp("1x128",   8'd1,   8'd128, 16'h0080, 8, 0, 1'b0);
        runOp("0x255",   8'd0,   8'd255, 16'h0000, 8, 0, 1'b0);
        runOp("hold",    8'd9,   8'd3,   16'd27,   2, 5, 1'b0);
        runOp("3x4",     8'd3,   8'd4,   16'd12,   3, 0, 1'b0);

        // Reset two cycles into RUN of 100*100.
        @(negedge clk);
        opA = 8'd100; opB = 8'd100; start = 1'b1;
        @(negedge clk);                       // after E0
        start = 1'b0;
        repeat (2) @(negedge clk);            // after E2
        chk("midRun busy0", busy0, 1);
        rst = 1'b1;
        #1;
        chkIdleReset("midRunRst");
        @(negedge clk);
        rst = 1'b0;
        runOp("100x100", 8'd100, 8'd100, 16'h2710, 7, 0, 1'b0);
        runOp("6x9scr",  8'd6,   8'd9,   16'd54,   4, 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
        $finish;
    end

endmodule
